// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE -> EXEC -> RESP, results registered in EXEC.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [2:0]       req_op_0,
  input  logic [2:0]       req_op_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       dbg_state
);

  // Handshake rule on both channels: a transfer happens at a rising edge where
  // valid and ready are both high; the requester holds valid and payload until then.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             any_valid;
  logic             owner_ready;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    any_valid = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid_1;
    end
    owner_ready = owner ? resp_ready_1 : resp_ready_0;
  end

  assign req_ready_0  = RST_n && (state == IDLE) && req_valid_0 && !grant;
  assign req_ready_1  = RST_n && (state == IDLE) && req_valid_1 && grant;
  assign resp_valid_0 = RST_n && (state == RESP) && !owner;
  assign resp_valid_1 = RST_n && (state == RESP) && owner;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner      <= grant;
            last_grant <= grant;
            a_q        <= grant ? req_a_1 : req_a_0;
            b_q        <= grant ? req_b_1 : req_b_0;
            op_q       <= grant ? req_op_1 : req_op_0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          state       <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
